merge_stream_rr: RTL
====================

Name: merge_stream_rr

Overview:
- 4-input to 1-output AXI-stream packet merger with round-robin arbitration.
- Sits downstream of the split/fifo stage. It recombines per-branch streams (e.g. after parallel processing) into one stream.
- Packet-atomic: once a grant is given, the whole packet through its tlast beat is forwarded before the grant moves on.
- Registered output stage, so no combinational path from i*_tvalid to o_tvalid.

Parameters:
- WIDTH, 16, tdata width in bits.
- ACTIVE_MASK, 4'b1111, bit N=1 enables input N. Masked inputs are never granted and their tready is held 0.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear, same effect as reset.
- i0_tdata / i1_tdata / i2_tdata / i3_tdata  input  WIDTH  input N data.
- i0_tlast / i1_tlast / i2_tlast / i3_tlast  input  1  input N end of packet.
- i0_tvalid / i1_tvalid / i2_tvalid / i3_tvalid  input  1  input N valid.
- i0_tready / i1_tready / i2_tready / i3_tready  output  1  input N ready.
- o_tdata  output  WIDTH  merged data.
- o_tlast  output  1  merged end of packet.
- o_tvalid  output  1  merged valid.
- o_tready  input  1  downstream ready.

Behaviour:
- Clock and reset (already decided): single clock clk; reset is synchronous and active-high. clear has identical effect.
- Reset/clear values: o_tvalid=0, o_tlast=0, o_tdata=0, all iN_tready=0, state=IDLE, last_grant=3 (input 0 gets first priority).
- States:
  - IDLE: scan inputs in order last_grant+1, +2, +3, +4 (mod 4). Consider only inputs with ACTIVE_MASK bit set and tvalid=1. On the first match, register sel=N and go to ACTIVE. No match: stay in IDLE. All iN_tready=0 in IDLE.
  - ACTIVE: isel_tready = (!o_tvalid | o_tready). All other iN_tready=0.
    - On an input handshake: o_tdata/o_tlast load from input sel and o_tvalid<=1.
    - If the accepted beat has tlast=1: last_grant<=sel, go to IDLE.
- Output register:
  - o_tvalid clears on (o_tvalid & o_tready) when no new beat loads in the same cycle.
  - Load and drain in the same cycle is allowed, giving full throughput within a packet.
- Latency: a beat accepted at edge k is visible on o_* after edge k.
- Packet gap: exactly one idle input cycle between packets, for re-arbitration in IDLE.
- Fairness: with all 4 inputs continuously valid, the grant order is 0,1,2,3,0,... Any input waits at most 3 packets.
- Single-beat packet (tvalid with tlast=1 on the first beat): ACTIVE lasts one cycle.
- Backpressure: o_tready=0 while o_tvalid=1 holds o_* stable and drives isel_tready=0. No beat is lost or duplicated.
- Stream rules:
  - A granted input dropping tvalid mid-packet keeps the grant; the block waits indefinitely.
  - Valids on non-selected inputs are ignored until IDLE.
- reset/clear mid-packet: the state machine, output register and last_grant return to reset values immediately. Any partial packet downstream is truncated; this is the user's responsibility.
- Output ordering within a packet is preserved. Packets from different inputs never interleave.

Optional Feature:
- Macro: MERGE_STREAM_RR_SRC_TAG_EN.
- When defined: adds output port o_tsrc (2 bits), registered alongside o_tdata. It holds the index of the input that produced the current beat and is valid whenever o_tvalid=1. Its reset value is 0.
- When undefined: the port and its register are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then a single 3-beat packet on i2 (data 0x0A,0x0B,0x0C, tlast on 0x0C), o_tready=1:
  - o_* shows 0x0A,0x0B,0x0C on consecutive cycles, with o_tlast only on 0x0C.
  - First o_tvalid appears 2 cycles after i2_tvalid rises: 1 cycle arbitration + 1 cycle register.
- All 4 inputs continuously valid with 2-beat packets, 16 packets total:
  - Source order is 0,1,2,3 repeated 4 times. Every packet is contiguous, with a 1-cycle o_tvalid gap between packets.
- i1 packet in flight, drop o_tready for 5 cycles mid-packet:
  - o_tdata stays constant and i1_tready=0 for those cycles.
  - Afterwards the remaining beats arrive in order; no loss or duplication.
- ACTIVE_MASK=4'b0101, all inputs valid: only inputs 0 and 2 are granted, alternating. i1_tready and i3_tready are always 0.
- Assert clear during beat 2 of a 4-beat i3 packet:
  - Next cycle o_tvalid=0 and state is IDLE.
  - With all inputs valid afterwards, the first grant is input 0.
- With MERGE_STREAM_RR_SRC_TAG_EN defined, repeat the 4-input round-robin test: o_tsrc matches the source index (0,1,2,3) on every beat.

Source files
------------

// File: rtl/merge_stream_rr.sv
// 4:1 packet-atomic round-robin AXI-stream merger; optional o_tsrc source tag (MERGE_STREAM_RR_SRC_TAG_EN).
// Latency: 1 arbitration cycle + 1 output register cycle; one idle input cycle between packets.
// Backpressure: granted input's tready = !o_tvalid | o_tready; o_* held stable while stalled.
module merge_stream_rr #(
   parameter int         WIDTH       = 16,
   parameter logic [3:0] ACTIVE_MASK = 4'b1111
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] i0_tdata,
   input  logic             i0_tlast,
   input  logic             i0_tvalid,
   output logic             i0_tready,
   input  logic [WIDTH-1:0] i1_tdata,
   input  logic             i1_tlast,
   input  logic             i1_tvalid,
   output logic             i1_tready,
   input  logic [WIDTH-1:0] i2_tdata,
   input  logic             i2_tlast,
   input  logic             i2_tvalid,
   output logic             i2_tready,
   input  logic [WIDTH-1:0] i3_tdata,
   input  logic             i3_tlast,
   input  logic             i3_tvalid,
   output logic             i3_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready
`ifdef MERGE_STREAM_RR_SRC_TAG_EN
   ,
   output logic [1:0]       o_tsrc
`endif
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_sel;
   logic [1:0]       w_sel_nxt;
   logic [1:0]       r_last_grant;
   logic [1:0]       w_last_grant_nxt;
   logic             w_found;
   logic [1:0]       w_idx;

   logic [WIDTH-1:0] w_tdata [4];
   logic [3:0]       w_tlast;
   logic [3:0]       w_tvalid;
   logic [3:0]       w_tready;

   logic             w_sync_rst;
   logic             w_out_free;
   logic             w_accept;

   logic [WIDTH-1:0] r_tdata;
   logic             r_tlast;
   logic             r_tvalid;

   assign w_tdata[0] = i0_tdata;
   assign w_tdata[1] = i1_tdata;
   assign w_tdata[2] = i2_tdata;
   assign w_tdata[3] = i3_tdata;
   assign w_tlast    = {i3_tlast, i2_tlast, i1_tlast, i0_tlast};
   assign w_tvalid   = {i3_tvalid, i2_tvalid, i1_tvalid, i0_tvalid};

   // clear is a full soft reset: FSM, grant pointer and output register all return to reset values
   assign w_sync_rst = reset | clear;

   // the output register can take a new beat when empty or draining this cycle
   assign w_out_free = !r_tvalid || o_tready;
   assign w_accept   = (r_state == S_ACTIVE) && w_out_free && w_tvalid[r_sel];

   // state register: grant holder, current selection and round-robin pointer
   always_ff @(posedge clk) begin
      if (w_sync_rst) begin
         r_state      <= S_IDLE;
         r_sel        <= 2'd0;
         r_last_grant <= 2'd3;
      end else begin
         r_state      <= w_state_nxt;
         r_sel        <= w_sel_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   // next state: rotating-priority scan in IDLE, release the grant after the tlast beat is taken
   always_comb begin
      w_state_nxt      = r_state;
      w_sel_nxt        = r_sel;
      w_last_grant_nxt = r_last_grant;
      w_found          = 1'b0;
      w_idx            = 2'd0;
      case (r_state)
         S_IDLE: begin
            for (int k = 1; k <= 4; k++) begin
               w_idx = r_last_grant + 2'(k);
               if (!w_found && ACTIVE_MASK[w_idx] && w_tvalid[w_idx]) begin
                  w_found     = 1'b1;
                  w_sel_nxt   = w_idx;
                  w_state_nxt = S_ACTIVE;
               end
            end
         end
         S_ACTIVE: begin
            if (w_accept && w_tlast[r_sel]) begin
               w_last_grant_nxt = r_sel;
               w_state_nxt      = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ready only toward the granted, enabled input while ACTIVE
   always_comb begin
      w_tready = 4'b0000;
      if (r_state == S_ACTIVE && ACTIVE_MASK[r_sel]) begin
         w_tready[r_sel] = w_out_free;
      end
   end

   assign i0_tready = w_tready[0];
   assign i1_tready = w_tready[1];
   assign i2_tready = w_tready[2];
   assign i3_tready = w_tready[3];

   // output register: load on input handshake, drop valid once drained with nothing new behind it
   always_ff @(posedge clk) begin
      if (w_sync_rst) begin
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
      end else if (w_accept) begin
         r_tvalid <= 1'b1;
         r_tlast  <= w_tlast[r_sel];
         r_tdata  <= w_tdata[r_sel];
      end else if (o_tready) begin
         r_tvalid <= 1'b0;
      end
   end

   assign o_tdata  = r_tdata;
   assign o_tlast  = r_tlast;
   assign o_tvalid = r_tvalid;

`ifdef MERGE_STREAM_RR_SRC_TAG_EN
   logic [1:0] r_tsrc;

   // source tag travels with the data beat it describes
   always_ff @(posedge clk) begin
      if (w_sync_rst) begin
         r_tsrc <= 2'd0;
      end else if (w_accept) begin
         r_tsrc <= r_sel;
      end
   end

   assign o_tsrc = r_tsrc;
`endif

endmodule
